instruction_issuer: RTL and testbench

//   Sending side of the processor instruction port. Holds a small program of Isa::Instruction words,

---
 rtl/instruction_issuer_pkg.sv | 28 ++
 rtl/instruction_issuer_memory.sv | 31 +++
 rtl/instruction_issuer.sv | 174 +++++++++++++++++
 tb/tb_instruction_issuer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_issuer_pkg.sv
// Isa package: instruction word format shared by the loader, the issuer and the processor.
package Isa;

    localparam int REGISTER_SIZE        = 16;
    localparam int REG_IDX_W            = $clog2(REGISTER_SIZE);
    localparam int ISSUER_DEPTH_DEFAULT = 16;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        ADD   = 3'd1,
        SUB   = 3'd2,
        AND   = 3'd3,
        OR    = 3'd4,
        XOR   = 3'd5,
        LOAD  = 3'd6,
        STORE = 3'd7
    } OpCode;

    typedef struct packed {
        OpCode                op_code;
        logic [REG_IDX_W-1:0] dest;
        logic [REG_IDX_W-1:0] src_a;
        logic [REG_IDX_W-1:0] src_b;
    } Instruction;

    localparam int INSTR_W = $bits(Instruction);

endpackage

// File: rtl/instruction_issuer_memory.sv
// program_memory: DEPTH x WIDTH program store, one write port and one registered read port.
module program_memory #(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 15,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // No reset on purpose: the program must survive an issuer reset.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/instruction_issuer.sv
// instruction_issuer: issues a loaded program word by word over valid/ready, one in flight at a time.
// Optional ISSUER_PERF_COUNT_EN adds busy-cycle and stall-cycle counters.
//
// state | meaning
// IDLE  | out of reset, no run yet; loads accepted
// READ  | program memory read of slot pc in progress
// ISSUE | o_valid high, waiting for i_ready
// WAIT  | instruction accepted, waiting for i_done
// HALT  | run complete; loads accepted, o_halted high
module instruction_issuer
    import Isa::*;
#(
    parameter  int DEPTH  = ISSUER_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load_valid,
    input  logic [ADDR_W-1:0]  i_load_addr,
    input  logic [INSTR_W-1:0] i_load_instruction,
    output logic               o_load_reject,
    input  logic [ADDR_W:0]    i_length,
    input  logic               i_start,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_valid,
    input  logic               i_ready,
    input  logic               i_done,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy,
    output logic               o_halted
`ifdef ISSUER_PERF_COUNT_EN
    ,
    output logic [31:0]        o_cycle_count,
    output logic [31:0]        o_stall_count
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               have_instr_q, have_instr_d;
    logic               load_reject_q, load_reject_d;
    logic               busy, idle_or_halt, start_ok, load_ok, last_word;
    logic [ADDR_W:0]    length_sat;
    logic [INSTR_W-1:0] rd_data;

    assign idle_or_halt = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign busy         = (state_q == ST_READ) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign start_ok     = i_start && idle_or_halt;
    assign load_ok      = i_load_valid && idle_or_halt;
    assign length_sat   = (i_length > LEN_MAX) ? LEN_MAX : i_length;
    assign last_word    = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        len_d         = len_q;
        have_instr_d  = have_instr_q;
        load_reject_d = i_load_valid && busy;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (i_start) begin
                    pc_d = '0;
                    if (length_sat == '0) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_READ;
                        len_d   = length_sat;
                    end
                end
            end
            ST_READ: begin
                state_d      = ST_ISSUE;
                have_instr_d = 1'b1;
            end
            ST_ISSUE: begin
                if (i_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_done) begin
                    if (last_word) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_READ;
                        pc_d    = pc_q + (ADDR_W)'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            have_instr_q  <= 1'b0;
            load_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            len_q         <= len_d;
            have_instr_q  <= have_instr_d;
            load_reject_q <= load_reject_d;
        end
    end

    program_memory #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_program_memory (
        .i_clock   (i_clock),
        .i_wr_en   (load_ok),
        .i_wr_addr (i_load_addr),
        .i_wr_data (i_load_instruction),
        .i_rd_en   (state_q == ST_READ),
        .i_rd_addr (pc_q),
        .o_rd_data (rd_data)
    );

    // The memory read register has no reset, so mask it until the first read after reset.
    assign o_instruction = have_instr_q ? rd_data : '0;
    assign o_valid       = (state_q == ST_ISSUE);
    assign o_pc          = pc_q;
    assign o_busy        = busy;
    assign o_halted      = (state_q == ST_HALT);
    assign o_load_reject = load_reject_q;

`ifdef ISSUER_PERF_COUNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        stall_count_d = stall_count_q;
        if (start_ok) begin
            cycle_count_d = '0;
            stall_count_d = '0;
        end else begin
            if (busy && (cycle_count_q != '1)) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end
            if ((state_q == ST_ISSUE) && !i_ready && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cycle_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_cycle_count = cycle_count_q;
    assign o_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed self-checking bench for instruction_issuer (DEPTH 16).
module tb_instruction_issuer;
    import Isa::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic               i_clock;
    logic               i_reset;
    logic               i_load_valid;
    logic [ADDR_W-1:0]  i_load_addr;
    logic [INSTR_W-1:0] i_load_instruction;
    logic               o_load_reject;
    logic [ADDR_W:0]    i_length;
    logic               i_start;
    logic [INSTR_W-1:0] o_instruction;
    logic               o_valid;
    logic               i_ready;
    logic               i_done;
    logic [ADDR_W-1:0]  o_pc;
    logic               o_busy;
    logic               o_halted;
`ifdef ISSUER_PERF_COUNT_EN
    logic [31:0]        o_cycle_count;
    logic [31:0]        o_stall_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    Instruction prog [6];
    Instruction w_new;

    instruction_issuer #(.DEPTH(DEPTH)) dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_load_valid       (i_load_valid),
        .i_load_addr        (i_load_addr),
        .i_load_instruction (i_load_instruction),
        .o_load_reject      (o_load_reject),
        .i_length           (i_length),
        .i_start            (i_start),
        .o_instruction      (o_instruction),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .i_done             (i_done),
        .o_pc               (o_pc),
        .o_busy             (o_busy),
        .o_halted           (o_halted)
`ifdef ISSUER_PERF_COUNT_EN
        ,
        .o_cycle_count      (o_cycle_count),
        .o_stall_count      (o_stall_count)
`endif
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] addr, input Instruction w);
        i_load_valid       = 1'b1;
        i_load_addr        = addr;
        i_load_instruction = w;
        step();
        i_load_valid       = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (o_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (o_valid === 1'b1);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_load_valid = 1'b0; i_load_addr = '0; i_load_instruction = '0;
        i_length = '0; i_start = 1'b0; i_ready = 1'b0; i_done = 1'b0;
        step(); step();
        i_reset = 1'b0;
        n_compared++;
        if ({o_valid, o_busy, o_halted, o_load_reject} !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL reset_flags: got v/b/h/r=%b expected 0000", {o_valid, o_busy, o_halted, o_load_reject});
        end
        n_compared++;
        if (o_pc !== 4'd0 || o_instruction !== '0) begin
            n_mismatched++;
            $display("FAIL reset_pc_instr: got pc=%0d instr=%h expected 0/0", o_pc, o_instruction);
        end
    endtask

    task automatic test_program();
        bit ok;
        for (int k = 0; k < 4; k++) load_word(k[ADDR_W-1:0], prog[k]);
        i_length = 5'd4; i_start = 1'b1; i_ready = 1'b1;
        step();
        i_start = 1'b0;
        n_compared++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL prog_read_state: got busy=%b valid=%b expected 1/0", o_busy, o_valid);
        end
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            n_compared++;
            if (!ok || o_instruction !== prog[k] || o_pc !== k[ADDR_W-1:0]) begin
                n_mismatched++;
                $display("FAIL prog_issue%0d: got valid=%b instr=%h pc=%0d expected 1/%h/%0d",
                         k, o_valid, o_instruction, o_pc, prog[k], k);
            end
            step();
            n_compared++;
            if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
                n_mismatched++;
                $display("FAIL prog_wait%0d: got valid=%b busy=%b expected 0/1", k, o_valid, o_busy);
            end
            step();
            i_done = 1'b1;
            step();
            i_done = 1'b0;
        end
        n_compared++;
        if (o_halted !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL prog_halt: got halted=%b busy=%b valid=%b expected 1/0/0", o_halted, o_busy, o_valid);
        end
    endtask

    task automatic test_stall();
        i_ready = 1'b0; i_length = 5'd1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        n_compared++;
        if (o_halted !== 1'b0 || o_busy !== 1'b1) begin
            n_mismatched++;
            $display("FAIL restart_from_halt: got halted=%b busy=%b expected 0/1", o_halted, o_busy);
        end
        step();
        for (int c = 0; c < 5; c++) begin
            n_compared++;
            if (o_valid !== 1'b1 || o_instruction !== prog[0]) begin
                n_mismatched++;
                $display("FAIL stall_hold%0d: got valid=%b instr=%h expected 1/%h", c, o_valid, o_instruction, prog[0]);
            end
            step();
        end
`ifdef ISSUER_PERF_COUNT_EN
        n_compared++;
        if (o_stall_count !== 32'd5) begin
            n_mismatched++;
            $display("FAIL stall_count: got %0d expected 5", o_stall_count);
        end
`endif
        i_ready = 1'b1;
        step();
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        n_compared++;
        if (o_halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL stall_halt: got halted=%b expected 1", o_halted);
        end
`ifdef ISSUER_PERF_COUNT_EN
        n_compared++;
        if (o_cycle_count !== 32'd9) begin
            n_mismatched++;
            $display("FAIL cycle_count: got %0d expected 9", o_cycle_count);
        end
`endif
    endtask

    task automatic test_load_reject();
        bit ok;
        load_word(4'd4, prog[4]);
        load_word(4'd5, prog[5]);
        i_ready = 1'b0; i_length = 5'd1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        load_word(4'd5, w_new);
        n_compared++;
        if (o_load_reject !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reject_pulse: got %b expected 1", o_load_reject);
        end
        step();
        n_compared++;
        if (o_load_reject !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reject_width: got %b expected 0", o_load_reject);
        end
        i_ready = 1'b1; i_done = 1'b1;
        step(); step();
        i_length = 5'd6; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_valid(ok);
            n_compared++;
            if (!ok || o_instruction !== prog[k] || o_pc !== k[ADDR_W-1:0]) begin
                n_mismatched++;
                $display("FAIL reject_keep%0d: got valid=%b instr=%h pc=%0d expected 1/%h/%0d",
                         k, o_valid, o_instruction, o_pc, prog[k], k);
            end
            step();
        end
        step();
        i_done = 1'b0;
        n_compared++;
        if (o_halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reject_halt: got halted=%b expected 1", o_halted);
        end
    endtask

    task automatic test_length_zero();
        int seen = 0;
        i_length = 5'd0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        n_compared++;
        if (o_halted !== 1'b1 || o_busy !== 1'b0) begin
            n_mismatched++;
            $display("FAIL len0_halt: got halted=%b busy=%b expected 1/0", o_halted, o_busy);
        end
        for (int c = 0; c < 4; c++) begin
            if (o_valid !== 1'b0) seen++;
            step();
        end
        n_compared++;
        if (seen != 0) begin
            n_mismatched++;
            $display("FAIL len0_no_valid: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_done_ignored();
        i_ready = 1'b0; i_length = 5'd1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        n_compared++;
        if (o_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL early_done_issue: got valid=%b expected 1", o_valid);
        end
        i_ready = 1'b1;
        step();
        step(); step(); step();
        n_compared++;
        if (o_busy !== 1'b1 || o_halted !== 1'b0 || o_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL early_done_wait: got busy=%b halted=%b valid=%b expected 1/0/0", o_busy, o_halted, o_valid);
        end
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        n_compared++;
        if (o_halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL early_done_halt: got halted=%b expected 1", o_halted);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int issues = 0;
        int n = 0;
        Instruction first_w = '0;
        logic [ADDR_W-1:0] first_pc = '1;
        i_ready = 1'b1; i_length = 5'd4; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(ok);
            step();
            if (k < 2) begin
                step();
                i_done = 1'b1;
                step();
                i_done = 1'b0;
            end
        end
        n_compared++;
        if (o_pc !== 4'd2 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL pre_reset_wait: got pc=%0d busy=%b valid=%b expected 2/1/0", o_pc, o_busy, o_valid);
        end
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        n_compared++;
        if ({o_valid, o_busy, o_halted, o_load_reject} !== 4'b0000 || o_pc !== 4'd0 || o_instruction !== '0) begin
            n_mismatched++;
            $display("FAIL midrun_reset: got v/b/h/r=%b pc=%0d instr=%h expected 0000/0/0",
                     {o_valid, o_busy, o_halted, o_load_reject}, o_pc, o_instruction);
        end
`ifdef ISSUER_PERF_COUNT_EN
        n_compared++;
        if (o_cycle_count !== 32'd0 || o_stall_count !== 32'd0) begin
            n_mismatched++;
            $display("FAIL midrun_reset_counts: got %0d/%0d expected 0/0", o_cycle_count, o_stall_count);
        end
`endif
        i_done = 1'b1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        while (o_halted !== 1'b1 && n < 60) begin
            if (o_valid === 1'b1) begin
                if (issues == 0) begin
                    first_w  = o_instruction;
                    first_pc = o_pc;
                end
                issues++;
            end
            step();
            n++;
        end
        i_done = 1'b0;
        n_compared++;
        if (first_w !== prog[0] || first_pc !== 4'd0 || issues != 4 || o_halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reissue_after_reset: got instr=%h pc=%0d issues=%0d halted=%b expected %h/0/4/1",
                     first_w, first_pc, issues, o_halted, prog[0]);
        end
    endtask

    task automatic test_length_saturate();
        int issues = 0;
        int n = 0;
        logic [ADDR_W-1:0] last_pc = '0;
        i_ready = 1'b1; i_done = 1'b1; i_length = 5'd31; i_start = 1'b1;
        step();
        i_start = 1'b0;
        while (o_halted !== 1'b1 && n < 200) begin
            if (o_valid === 1'b1) begin
                issues++;
                last_pc = o_pc;
            end
            step();
            n++;
        end
        i_done = 1'b0;
        n_compared++;
        if (issues != 16 || last_pc !== 4'd15 || o_halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL length_saturate: got issues=%0d last_pc=%0d halted=%b expected 16/15/1",
                     issues, last_pc, o_halted);
        end
        n_compared++;
        if (n != 48) begin
            n_mismatched++;
            $display("FAIL issue_period: got %0d cycles for 16 words expected 48", n);
        end
    endtask

    task automatic test_load_and_start();
        i_ready = 1'b0; i_length = 5'd1; i_start = 1'b1;
        i_load_valid = 1'b1; i_load_addr = 4'd0; i_load_instruction = w_new;
        step();
        i_start = 1'b0; i_load_valid = 1'b0;
        step();
        n_compared++;
        if (o_valid !== 1'b1 || o_instruction !== w_new) begin
            n_mismatched++;
            $display("FAIL load_and_start: got valid=%b instr=%h expected 1/%h", o_valid, o_instruction, w_new);
        end
        i_ready = 1'b1; i_done = 1'b1;
        step(); step();
        i_done = 1'b0;
        n_compared++;
        if (o_halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL load_and_start_halt: got halted=%b expected 1", o_halted);
        end
    endtask

    initial begin
        prog[0] = '{op_code: ADD,  dest: 4'd3, src_a: 4'd1, src_b: 4'd2};
        prog[1] = '{op_code: SUB,  dest: 4'd4, src_a: 4'd3, src_b: 4'd1};
        prog[2] = '{op_code: AND,  dest: 4'd5, src_a: 4'd4, src_b: 4'd2};
        prog[3] = '{op_code: OR,   dest: 4'd6, src_a: 4'd5, src_b: 4'd1};
        prog[4] = '{op_code: LOAD, dest: 4'd7, src_a: 4'd0, src_b: 4'd0};
        prog[5] = '{op_code: XOR,  dest: 4'd1, src_a: 4'd2, src_b: 4'd3};
        w_new   = '{op_code: STORE, dest: 4'd9, src_a: 4'd9, src_b: 4'd9};

        test_reset();
        test_program();
        test_stall();
        test_load_reject();
        test_length_zero();
        test_done_ignored();
        test_reset_mid_run();
        test_length_saturate();
        test_load_and_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
